// File: rtl/uart_rx.sv
// uart_rx: 8-bit serial receiver (1 start, 8 data LSB first, optional parity, 1 stop) with a one-entry holding register.
// Latency: byte or error pulse is registered on the edge after the mid-stop sample (2 sync + 1 detect + half bit + 9/10 bit times).
// Backpressure: rx_valid/rx_ready; a good byte arriving while the register is full and not being accepted is dropped with an overrun pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       SYS_CLK,
  input  logic       RSTn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]    sync_q;
  logic          rxs;
  logic [1:0]    fill_q;
  logic          armed_q, armed_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          par_bad_q, par_bad_d;
  logic          deliver;
  logic          frame_d, parity_d, overrun_d;
  logic          frame_q, parity_q, overrun_q;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;

  assign rxs = sync_q[1];

  // Two-flop synchronizer for the asynchronous line; resets to the idle (high) level.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  // Marks when rxs carries a real line sample rather than the reset value, so a line
  // held low through reset is not mistaken for a start bit.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      fill_q <= 2'b00;
    end else begin
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  // Receiver FSM state, counters and assembly registers.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_bad_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_bad_q <= par_bad_d;
      armed_q   <= armed_d;
    end
  end

  // Next-state logic: start qualification at mid-start, then one sample per bit time at mid-bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_bad_d = par_bad_q;
    armed_d   = armed_q;
    deliver   = 1'b0;
    frame_d   = 1'b0;
    parity_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // The line must be seen high once after reset before a falling level counts as a start.
        if (fill_q[1] && rxs) begin
          armed_d = 1'b1;
        end
        if (armed_q && !rxs) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          idx_d     = '0;
          par_bad_d = 1'b0;
          state_d   = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d         = '0;
          data_d[idx_q] = rxs;
          idx_d         = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = (rxs != ((^data_q) ^ PARITY_ODD));
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rxs) begin
            frame_d = 1'b1;
            state_d = S_BREAK;
          end else if (par_bad_q) begin
            parity_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        // Hold here through a long low line so it reports a single framing error.
        cnt_d = '0;
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Holding register: a delivery wins over a clear when it coincides with an accept.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    overrun_d  = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d = 1'b1;
        rx_data_d  = data_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // Output registers: holding register and single-cycle error pulses.
  always_ff @(posedge SYS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      frame_q    <= 1'b0;
      parity_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frame_q    <= frame_d;
      parity_q   <= parity_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_q;
  assign parity_err = parity_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives two receivers (no parity / odd parity) with directed and random frames.
// Expected outputs come from a frame-level model: each sent frame schedules one outcome at its mid-stop edge.
// Outputs are compared on every falling edge; directed checks pin latency and pulse counts with literals.
module tb_uart_rx;

  localparam int CPB0 = 24;
  localparam int CPB1 = 17;
  localparam int EV_DATA  = 0;
  localparam int EV_FRAME = 1;
  localparam int EV_PAR   = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_l [2];
  logic       rdy  [2];
  logic [7:0] dat  [2];
  logic       vld  [2];
  logic       ferr [2];
  logic       perr [2];
  logic       ovr  [2];
  logic       bsy  [2];

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  bit         m_vld  [2];
  logic [7:0] m_dat  [2];
  bit         m_ferr [2];
  bit         m_perr [2];
  bit         m_ovr  [2];
  ev_t        q0 [$];
  ev_t        q1 [$];

  int         last_k   [2];
  int         n_vld    [2];
  int         n_ferr   [2];
  int         n_perr   [2];
  int         n_ovr    [2];
  int         busy_cnt [2];
  int         rise_cyc [2];
  logic [7:0] rise_dat [2];
  bit         pv       [2];
  bit         rnd_done;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB0), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
    .SYS_CLK(clk), .RSTn(rst_n), .rx(rx_l[0]), .rx_data(dat[0]), .rx_valid(vld[0]),
    .rx_ready(rdy[0]), .frame_err(ferr[0]), .parity_err(perr[0]), .overrun(ovr[0]), .busy(bsy[0])
  );

  uart_rx #(.CLKS_PER_BIT(CPB1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut1 (
    .SYS_CLK(clk), .RSTn(rst_n), .rx(rx_l[1]), .rx_data(dat[1]), .rx_valid(vld[1]),
    .rx_ready(rdy[1]), .frame_err(ferr[1]), .parity_err(perr[1]), .overrun(ovr[1]), .busy(bsy[1])
  );

  function automatic int cpb(input int d);
    return (d == 0) ? CPB0 : CPB1;
  endfunction

  // Samples taken after start qualification: 8 data + stop, plus parity on unit 1.
  function automatic int nsamp(input int d);
    return (d == 0) ? 9 : 10;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input int d, input logic v, input int n);
    rx_l[d] = v;
    tick(n);
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_vld[d]  = 1'b0;
      m_dat[d]  = 8'h00;
      m_ferr[d] = 1'b0;
      m_perr[d] = 1'b0;
      m_ovr[d]  = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Frame model: apply the outcome scheduled for this edge, then the consumer handshake.
  task automatic model_step(input int d);
    ev_t e;
    bit  have;
    have      = 1'b0;
    m_ferr[d] = 1'b0;
    m_perr[d] = 1'b0;
    m_ovr[d]  = 1'b0;
    if (d == 0) begin
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
        e = q0.pop_front();
        have = 1'b1;
      end
    end else begin
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        e = q1.pop_front();
        have = 1'b1;
      end
    end
    if (have && e.kind == EV_DATA) begin
      if (!m_vld[d] || rdy[d]) begin
        m_vld[d] = 1'b1;
        m_dat[d] = e.data;
      end else begin
        m_ovr[d] = 1'b1;
      end
    end else begin
      if (have && e.kind == EV_FRAME) m_ferr[d] = 1'b1;
      if (have && e.kind == EV_PAR)   m_perr[d] = 1'b1;
      if (m_vld[d] && rdy[d]) m_vld[d] = 1'b0;
    end
  endtask

  // Sends one frame starting now; the outcome lands at detect (3) + half bit + nsamp bit times.
  task automatic send(input int d, input logic [7:0] b, input bit bad_par, input int stop_low);
    ev_t ev;
    int  c;
    c = cpb(d);
    last_k[d] = cyc;
    ev.cyc  = cyc + 3 + c / 2 + nsamp(d) * c;
    ev.data = b;
    if (stop_low > 0)  ev.kind = EV_FRAME;
    else if (bad_par)  ev.kind = EV_PAR;
    else               ev.kind = EV_DATA;
    if (d == 0) q0.push_back(ev);
    else        q1.push_back(ev);
    drive_bit(d, 1'b0, c);
    for (int i = 0; i < 8; i++) drive_bit(d, b[i], c);
    if (d == 1) drive_bit(d, (^b) ^ 1'b1 ^ bad_par, c);
    if (stop_low > 0) drive_bit(d, 1'b0, stop_low * c);
    drive_bit(d, 1'b1, c);
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_data"}, dat[d], 32'h0);
    chk({tag, "_valid"}, vld[d], 32'h0);
    chk({tag, "_ferr"}, ferr[d], 32'h0);
    chk({tag, "_perr"}, perr[d], 32'h0);
    chk({tag, "_ovr"}, ovr[d], 32'h0);
    chk({tag, "_busy"}, bsy[d], 32'h0);
  endtask

  task automatic rand_frames(input int d, input int n);
    logic [7:0] b;
    bit         bp;
    int         sl;
    for (int i = 0; i < n; i++) begin
      b  = 8'($urandom_range(0, 255));
      bp = (d == 1) && ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      send(d, b, bp, sl);
      tick($urandom_range(0, 30));
    end
  endtask

  // Cycle counter and model advance at the active edge, reading rdy before the bench changes it.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n) begin
        chk($sformatf("u%0d_valid", d), vld[d], m_vld[d]);
        if (m_vld[d]) chk($sformatf("u%0d_data", d), dat[d], m_dat[d]);
        chk($sformatf("u%0d_frame_err", d), ferr[d], m_ferr[d]);
        chk($sformatf("u%0d_parity_err", d), perr[d], m_perr[d]);
        chk($sformatf("u%0d_overrun", d), ovr[d], m_ovr[d]);
      end
      if (vld[d] === 1'b1)  n_vld[d]++;
      if (ferr[d] === 1'b1) n_ferr[d]++;
      if (perr[d] === 1'b1) n_perr[d]++;
      if (ovr[d] === 1'b1)  n_ovr[d]++;
      if (bsy[d] === 1'b1)  busy_cnt[d]++;
      if (vld[d] === 1'b1 && !pv[d]) begin
        rise_cyc[d] = cyc;
        rise_dat[d] = dat[d];
      end
      pv[d] = (vld[d] === 1'b1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv, nf, np, no, bc, e;
    for (int d = 0; d < 2; d++) begin
      n_vld[d] = 0; n_ferr[d] = 0; n_perr[d] = 0; n_ovr[d] = 0;
      busy_cnt[d] = 0; rise_cyc[d] = 0; rise_dat[d] = 8'h00; pv[d] = 1'b0; last_k[d] = 0;
    end
    model_clear();
    rnd_done = 1'b0;
    rst_n    = 1'b0;
    rx_l[0]  = 1'b1;
    rx_l[1]  = 1'b1;
    rdy[0]   = 1'b1;
    rdy[1]   = 1'b1;
    #1;
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    @(posedge clk);
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // Basic byte on the no-parity unit with the consumer always ready.
    nv = n_vld[0]; nf = n_ferr[0] + n_perr[0] + n_ovr[0]; bc = busy_cnt[0];
    send(0, 8'hA5, 1'b0, 0);
    tick(4);
    chk("basic_latency", rise_cyc[0] - last_k[0], 231);
    chk("basic_data", rise_dat[0], 8'hA5);
    chk("basic_valid_cycles", n_vld[0] - nv, 1);
    chk("basic_no_errors", n_ferr[0] + n_perr[0] + n_ovr[0] - nf, 0);
    chk("basic_busy_cycles", busy_cnt[0] - bc, 228);
    chk("basic_busy_after", bsy[0], 0);

    // Short low glitch: false start, busy only until mid-start.
    nv = n_vld[0]; nf = n_ferr[0] + n_perr[0] + n_ovr[0]; bc = busy_cnt[0];
    drive_bit(0, 1'b0, 6);
    drive_bit(0, 1'b1, 30);
    chk("glitch_busy_cycles", busy_cnt[0] - bc, 12);
    chk("glitch_no_valid", n_vld[0] - nv, 0);
    chk("glitch_no_errors", n_ferr[0] + n_perr[0] + n_ovr[0] - nf, 0);

    // Framing error with a long low stop, then recovery.
    nv = n_vld[0]; nf = n_ferr[0];
    send(0, 8'h3C, 1'b0, 3);
    tick(10);
    chk("frame_one_pulse", n_ferr[0] - nf, 1);
    chk("frame_no_valid", n_vld[0] - nv, 0);
    send(0, 8'h55, 1'b0, 0);
    tick(4);
    chk("frame_next_data", rise_dat[0], 8'h55);
    chk("frame_next_valid", n_vld[0] - nv, 1);

    // Overrun: consumer stalled across two back-to-back frames.
    rdy[0] = 1'b0;
    no = n_ovr[0];
    send(0, 8'h11, 1'b0, 0);
    send(0, 8'h22, 1'b0, 0);
    tick(4);
    chk("ovr_keep_data", dat[0], 8'h11);
    chk("ovr_keep_valid", vld[0], 1);
    chk("ovr_one_pulse", n_ovr[0] - no, 1);
    rdy[0] = 1'b1;
    tick(1);
    rdy[0] = 1'b0;
    tick(1);
    chk("ovr_drained", vld[0], 0);

    // Same pair, with an accept exactly on the second delivery edge.
    no = n_ovr[0];
    send(0, 8'h11, 1'b0, 0);
    fork
      send(0, 8'h22, 1'b0, 0);
      begin
        tick(1);
        e = last_k[0] + 3 + CPB0 / 2 + 9 * CPB0;
        while (cyc < e - 1) tick(1);
        rdy[0] = 1'b1;
        tick(1);
        rdy[0] = 1'b0;
      end
    join
    tick(2);
    chk("accept_new_data", dat[0], 8'h22);
    chk("accept_valid_held", vld[0], 1);
    chk("accept_no_overrun", n_ovr[0] - no, 0);
    rdy[0] = 1'b1;
    tick(2);

    // Odd parity on unit 1: 0x07 has three ones, so the good parity bit is 0.
    nv = n_vld[1]; np = n_perr[1];
    send(1, 8'h07, 1'b0, 0);
    tick(4);
    chk("par_good_data", rise_dat[1], 8'h07);
    chk("par_good_valid", n_vld[1] - nv, 1);
    nv = n_vld[1];
    send(1, 8'h07, 1'b1, 0);
    tick(4);
    chk("par_bad_pulse", n_perr[1] - np, 1);
    chk("par_bad_no_valid", n_vld[1] - nv, 0);

    // Reset in the middle of data bit 4 of 0xF0, line held low through and after reset.
    drive_bit(0, 1'b0, 5 * CPB0 + CPB0 / 2);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk_zero(0, "midrst");
    tick(3);
    rst_n = 1'b1;
    bc = busy_cnt[0];
    tick(20);
    chk("midrst_busy_low", busy_cnt[0] - bc, 0);
    drive_bit(0, 1'b1, 10);
    send(0, 8'h81, 1'b0, 0);
    tick(4);
    chk("midrst_next_data", rise_dat[0], 8'h81);

    // Random frames on both units with a randomly stalling consumer.
    fork
      begin
        fork
          rand_frames(0, 12);
          rand_frames(1, 10);
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rdy[0] = ($urandom_range(0, 3) != 0);
          rdy[1] = ($urandom_range(0, 3) != 0);
          tick(1);
        end
      end
    join
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    tick(40);
    chk("model_drained0", q0.size(), 0);
    chk("model_drained1", q1.size(), 0);
    chk("final_valid0", vld[0], 0);
    chk("final_valid1", vld[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8-bit asynchronous serial receiver, 8 data bits, 1 stop bit, optional parity. It is the receive-side counterpart of the board UART transmitter.
- Samples the expansion-header RX line (GPIO_02) in the SYS_CLK domain.
- Presents each received byte through a one-entry holding register with a valid/ready handshake.
- Reports framing, parity and overrun errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 434, SYS_CLK cycles per bit (50 MHz / 115200 baud); legal range 8..65535.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.

Ports:
- SYS_CLK  input  1  system clock, 50 MHz.
- RSTn  input  1  asynchronous active-low reset.
- rx  input  1  serial line; idles high; asynchronous to SYS_CLK.
- rx_data  output  8  received byte, valid while rx_valid = 1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready at a SYS_CLK edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch.
- overrun  output  1  one-cycle pulse: a good byte was dropped because the holding register was full.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (RSTn = 0, async):
  - Both synchronizer flops are set to 1.
  - FSM goes to IDLE; bit counter and clock counter are cleared to 0.
  - rx_data = 0x00; rx_valid, frame_err, parity_err, overrun and busy are all 0.
- Reset mid-frame abandons the frame with no output or error. After release, the receiver resumes in IDLE, which waits for rx high (see BREAK).
- Input synchronization: rx passes through a 2-flop synchronizer (rxs). All decisions use rxs only.
- Clock counter: counts 0..CLKS_PER_BIT-1. The bit index counts 0..7, and data is assembled LSB first.
- FSM states and transitions:
  - IDLE: on rxs = 0, go to START and clear the clock counter.
  - START: at count = CLKS_PER_BIT/2 - 1 (integer division), sample rxs.
    - rxs = 1: false start; return to IDLE with no pulse.
    - rxs = 0: go to DATA and restart the counter.
  - DATA: at each count = CLKS_PER_BIT-1, shift rxs into bit[index]. After bit 7, go to PARITY if PARITY_EN = 1, otherwise go to STOP. Sample points therefore fall at mid-bit.
  - PARITY: sample at CLKS_PER_BIT-1 and compare against the XOR of the data bits. The expected bit is that XOR for even parity and its inverse for odd parity. Record the mismatch, then go to STOP.
  - STOP: sample at CLKS_PER_BIT-1 (mid-stop).
    - rxs = 0: pulse frame_err, discard the byte, go to BREAK.
    - rxs = 1 with a parity mismatch: pulse parity_err, discard the byte, go to IDLE.
    - otherwise: deliver the byte and go to IDLE.
  - BREAK: wait until rxs = 1, then go to IDLE. A continuous low line produces exactly one frame_err.
- Latency and timing:
  - Delivery sets rx_valid = 1 and loads rx_data on the SYS_CLK edge after the mid-stop sample.
  - Error pulses are registered and occur on that same edge.
  - Because IDLE is re-entered at mid-stop, a back-to-back start bit is detected with no lost bit.
- Handshake:
  - rx_valid stays 1 and rx_data stays stable until rx_valid & rx_ready, which clears rx_valid on the next edge.
  - rx_ready has no effect while rx_valid = 0.
- Simultaneous events:
  - Delivery in the same cycle as an accept: load the new byte and keep rx_valid = 1; no overrun.
  - Delivery while rx_valid = 1 with no accept: pulse overrun, drop the new byte, keep the old one.
  - Discarded (errored) bytes never cause overrun.
- Width rules:
  - The clock counter width is clog2(CLKS_PER_BIT).
  - The counter never wraps silently: it is cleared at every sample point and on every state entry.

Test Plan:
- Basic byte: CLKS_PER_BIT = 434, PARITY_EN = 0, send 0xA5 at 115200 baud with rx_ready = 1 → rx_valid pulses for one cycle with rx_data = 0xA5; no error pulses; busy is 0 after mid-stop.
- Glitch: low pulse of 100 cycles on an idle line → no rx_valid and no errors; busy rises and then returns to 0 at mid-start.
- Framing error: send 0x3C with the stop bit held low for 3 bit times → one frame_err pulse; no rx_valid; next frame 0x55 is received correctly.
- Overrun and simultaneous accept:
  - rx_ready = 0, send 0x11 then 0x22 back-to-back → rx_data stays 0x11, one overrun pulse at the second mid-stop.
  - Repeat with rx_ready pulsed on the 0x22 delivery cycle → rx_data = 0x22, rx_valid stays 1, no overrun.
- Parity: PARITY_EN = 1, PARITY_ODD = 1.
  - Send 0x07 with parity bit 0 → rx_data = 0x07.
  - Send 0x07 with parity bit 1 → parity_err pulse, no rx_valid.
- Reset mid-frame: assert RSTn low during data bit 4 of 0xF0 with rx held low → all outputs 0 immediately and asynchronously. After release with rx low, busy stays 0 until rx goes high. A following 0x81 is received correctly.
